// File: rtl/sh7604_dbus_arb_pkg.sv
// rtl/sh7604_dbus_arb_pkg.sv - grant encoding and line-fill length shared by the DBUS arbiter
package sh7604_dbus_arb_pkg;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_CPU  = 2'd1,
    G_DMA  = 2'd2
  } dbus_gnt_t;

  localparam int DBUS_BURST_BEATS = 4;

endpackage

// File: rtl/sh7604_dbus_arb_if.sv
// rtl/sh7604_dbus_arb_if.sv - one DBUS-style request port; master issues beats, slave returns data/stall
interface sh7604_dbus_arb_if;
  logic [31:0] a;
  logic [31:0] wdata;
  logic [3:0]  ba;
  logic        we;
  logic        req;
  logic        burst;
  logic        lock;
  logic [31:0] rdata;
  logic        busy;

  modport master (output a, wdata, ba, we, req, burst, lock, input rdata, busy);
  modport slave  (input a, wdata, ba, we, req, burst, lock, output rdata, busy);
endinterface

// File: rtl/sh7604_dbus_arb.sv
// rtl/sh7604_dbus_arb.sv - CPU/DMAC arbiter in front of the SH7604 BSC DBUS port
// SH7604_DBUS_ARB_FAIR_EN: round-robin on contention instead of DMAC priority with starvation guard
module sh7604_dbus_arb
  import sh7604_dbus_arb_pkg::*;
#(
  parameter int BURST_BEATS  = DBUS_BURST_BEATS,
  parameter int DMA_HOLD_MAX = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    ce_r_i,
  input  logic                    ce_f_i,
  sh7604_dbus_arb_if.slave        cpu,
  sh7604_dbus_arb_if.slave        dma,
  sh7604_dbus_arb_if.master       dbus,
  output dbus_gnt_t               gnt_o,
  output logic [3:0]              beat_cnt_o,
  output logic [3:0]              hold_cnt_o
);

  dbus_gnt_t   gnt_q, gnt_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        last_cpu_q, last_cpu_d;
  logic        owner_req, accept, hold, rearb;

  logic unused_ok;
  assign unused_ok = ^{ce_f_i, dma.burst, dma.lock};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q      <= G_NONE;
      beat_cnt_q <= '0;
      hold_cnt_q <= '0;
      last_cpu_q <= 1'b0;
    end else if (ce_r_i) begin
      gnt_q      <= gnt_d;
      beat_cnt_q <= beat_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      last_cpu_q <= last_cpu_d;
    end
  end

  always_comb begin
    owner_req  = 1'b0;
    beat_cnt_d = beat_cnt_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    last_cpu_d = last_cpu_q;

    unique case (gnt_q)
      G_CPU:   owner_req = cpu.req;
      G_DMA:   owner_req = dma.req;
      default: owner_req = 1'b0;
    endcase
    accept = owner_req & ~dbus.busy;

    if (gnt_q == G_CPU) begin
      if (!cpu.req) begin
        beat_cnt_d = '0;
      end else if (accept && cpu.burst) begin
        beat_cnt_d = (beat_cnt_q == 4'(BURST_BEATS - 1)) ? 4'd0 : beat_cnt_q + 4'd1;
      end
    end

    if (gnt_q == G_DMA && accept && cpu.req && hold_cnt_q != 4'hF) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end

    // Hold looks at the post-beat count so the last fill beat releases on its own edge.
    hold  = (gnt_q == G_CPU) && (cpu.lock || (beat_cnt_d != 4'd0 && cpu.req));
    rearb = (gnt_q == G_NONE) || ((accept || !owner_req) && !hold);

    if (rearb) begin
      if (cpu.req && dma.req) begin
`ifdef SH7604_DBUS_ARB_FAIR_EN
        gnt_d = last_cpu_q ? G_DMA : G_CPU;
`else
        gnt_d = (hold_cnt_d == 4'(DMA_HOLD_MAX)) ? G_CPU : G_DMA;
`endif
      end else if (cpu.req) begin
        gnt_d = G_CPU;
      end else if (dma.req) begin
        gnt_d = G_DMA;
      end else begin
        gnt_d = G_NONE;
      end
      if (gnt_d == G_CPU) begin
        last_cpu_d = 1'b1;
        hold_cnt_d = '0;
      end else if (gnt_d == G_DMA) begin
        last_cpu_d = 1'b0;
      end
    end
  end

  // Bus mux keyed on the registered grant; idle drives all-zero.
  always_comb begin
    dbus.a     = '0;
    dbus.wdata = '0;
    dbus.ba    = '0;
    dbus.we    = 1'b0;
    dbus.req   = 1'b0;
    dbus.burst = 1'b0;
    dbus.lock  = 1'b0;
    unique case (gnt_q)
      G_CPU: begin
        dbus.a     = cpu.a;
        dbus.wdata = cpu.wdata;
        dbus.ba    = cpu.ba;
        dbus.we    = cpu.we;
        dbus.req   = cpu.req;
        dbus.burst = cpu.burst;
        dbus.lock  = cpu.lock;
      end
      G_DMA: begin
        dbus.a     = dma.a;
        dbus.wdata = dma.wdata;
        dbus.ba    = dma.ba;
        dbus.we    = dma.we;
        dbus.req   = dma.req;
      end
      default: ;
    endcase
  end

  assign cpu.rdata  = dbus.rdata;
  assign dma.rdata  = dbus.rdata;
  assign cpu.busy   = (gnt_q == G_CPU) ? dbus.busy : cpu.req;
  assign dma.busy   = (gnt_q == G_DMA) ? dbus.busy : dma.req;
  assign gnt_o      = gnt_q;
  assign beat_cnt_o = beat_cnt_q;
  assign hold_cnt_o = hold_cnt_q;

endmodule

// File: tb/tb_sh7604_dbus_arb.sv
// tb/tb_sh7604_dbus_arb.sv - scoreboard bench for the DBUS arbiter: expected beat order queued, monitor checks DBUS
module tb_sh7604_dbus_arb;
  import sh7604_dbus_arb_pkg::*;

  logic clk = 1'b0;
  logic rst, ce_r, ce_f;
  always #5 clk = ~clk;

  sh7604_dbus_arb_if cpu_bus ();
  sh7604_dbus_arb_if dma_bus ();
  sh7604_dbus_arb_if dbus_bus ();
  dbus_gnt_t  gnt;
  logic [3:0] beat_cnt, hold_cnt;

  sh7604_dbus_arb dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ce_r_i     (ce_r),
    .ce_f_i     (ce_f),
    .cpu        (cpu_bus),
    .dma        (dma_bus),
    .dbus       (dbus_bus),
    .gnt_o      (gnt),
    .beat_cnt_o (beat_cnt),
    .hold_cnt_o (hold_cnt)
  );

  typedef struct packed {
    logic [31:0] a;
    logic        we;
    logic        lock;
  } beat_t;

  beat_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  int          cpu_left = 0, cpu_idx = 0, dma_left = 0, dma_idx = 0;
  logic [31:0] cpu_base = '0, dma_base = '0;
  logic        cpu_inc = 1'b1, cpu_burst_cfg = 1'b0, cpu_lock_cfg = 1'b0;
  logic [7:0]  cpu_we_mask = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic we, input logic lock);
    beat_t b;
    b = {a, we, lock};
    exp_q.push_back(b);
  endtask

  task automatic drive();
    cpu_bus.req   = (cpu_left > 0);
    cpu_bus.a     = cpu_base + (cpu_inc ? 32'(cpu_idx * 4) : 32'd0);
    cpu_bus.wdata = cpu_bus.a ^ 32'h5A5A5A5A;
    cpu_bus.ba    = 4'hF;
    cpu_bus.we    = cpu_we_mask[cpu_idx % 8];
    cpu_bus.burst = cpu_burst_cfg && (cpu_left > 0);
    cpu_bus.lock  = cpu_lock_cfg && (cpu_left > 0);
    dma_bus.req   = (dma_left > 0);
    dma_bus.a     = dma_base + 32'(dma_idx * 4);
    dma_bus.wdata = ~dma_bus.a;
    dma_bus.ba    = 4'hF;
    dma_bus.we    = 1'b1;
    dma_bus.burst = 1'b0;
    dma_bus.lock  = 1'b0;
    #1;
  endtask

  task automatic step();
    logic ca, da;
    @(negedge clk);
    ca = cpu_bus.req && !cpu_bus.busy && ce_r;
    da = dma_bus.req && !dma_bus.busy && ce_r;
    @(posedge clk);
    #1;
    if (ca) begin cpu_left--; cpu_idx++; end
    if (da) begin dma_left--; dma_idx++; end
    drive();
  endtask

  task automatic drain(input string name, input int max_cyc);
    int c;
    c = 0;
    while ((cpu_left > 0 || dma_left > 0 || exp_q.size() > 0) && c < max_cyc) begin
      step();
      c++;
    end
    if (c >= max_cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d beats still expected after %0d cycles", name, exp_q.size(), c);
    end
  endtask

  // Monitor: every accepted DBUS beat must match the head of the expected queue.
  initial begin
    beat_t e, g;
    forever begin
      @(negedge clk);
      if (!rst && ce_r && dbus_bus.req && !dbus_bus.busy) begin
        g = {dbus_bus.a, dbus_bus.we, dbus_bus.lock};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_unexpected: got a=%h we=%b lock=%b expected no beat", g.a, g.we, g.lock);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL beat: got a=%h we=%b lock=%b expected a=%h we=%b lock=%b",
                     g.a, g.we, g.lock, e.a, e.we, e.lock);
          end
        end
      end
    end
  end

  initial begin
    int  c;
    bit  seen;
    rst  = 1'b1;
    ce_r = 1'b1;
    ce_f = 1'b0;
    dbus_bus.busy  = 1'b0;
    dbus_bus.rdata = 32'hCAFEF00D;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'(G_NONE));
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_hold_cnt", 32'(hold_cnt), 32'd0);
    chk("rst_cpu_busy", 32'(cpu_bus.busy), 32'd0);
    chk("rst_dma_busy", 32'(dma_bus.busy), 32'd0);
    chk("rst_dbus_req", 32'(dbus_bus.req), 32'd0);

    // Single CPU read, including a CE_R-gated cycle.
    cpu_base = 32'h06000010; cpu_left = 1; cpu_idx = 0; cpu_inc = 1'b1;
    cpu_burst_cfg = 1'b0; cpu_lock_cfg = 1'b0; cpu_we_mask = 8'h00;
    push(32'h06000010, 1'b0, 1'b0);
    drive();
    chk("s1_latency", 32'(dbus_bus.req), 32'd0);
    chk("s1_cpu_wait", 32'(cpu_bus.busy), 32'd1);
    ce_r = 1'b0;
    step();
    chk("s1_ce_gate", 32'(dbus_bus.req), 32'd0);
    ce_r = 1'b1;
    step();
    chk("s1_req", 32'(dbus_bus.req), 32'd1);
    chk("s1_gnt", 32'(gnt), 32'(G_CPU));
    chk("s1_dma_busy", 32'(dma_bus.busy), 32'd0);
    chk("s1_addr", dbus_bus.a, 32'h06000010);
    chk("s1_cpu_rdata", cpu_bus.rdata, 32'hCAFEF00D);
    chk("s1_dma_rdata", dma_bus.rdata, 32'hCAFEF00D);
    drain("s1", 20);
    repeat (2) step();
    chk("s1_idle", 32'(gnt), 32'(G_NONE));

    // CPU line fill; DMAC requests after the first beat and must wait for all four.
    cpu_base = 32'h06000100; cpu_left = 4; cpu_idx = 0; cpu_burst_cfg = 1'b1;
    for (int i = 0; i < 4; i++) push(32'h06000100 + 32'(4 * i), 1'b0, 1'b0);
    push(32'h0A000000, 1'b1, 1'b0);
    push(32'h0A000004, 1'b1, 1'b0);
    drive();
    step();
    step();
    chk("s2_beat_cnt1", 32'(beat_cnt), 32'd1);
    dma_base = 32'h0A000000; dma_left = 2; dma_idx = 0;
    drive();
    chk("s2_dma_stall", 32'(dma_bus.busy), 32'd1);
    step();
    chk("s2_dma_stall2", 32'(dma_bus.busy), 32'd1);
    chk("s2_beat_cnt2", 32'(beat_cnt), 32'd2);
    drain("s2", 40);
    chk("s2_beat_wrap", 32'(beat_cnt), 32'd0);
    cpu_burst_cfg = 1'b0;
    repeat (2) step();

    // Both requesting continuously.
    cpu_base = 32'h06000200; cpu_left = 2; cpu_idx = 0;
    dma_base = 32'h0A001000; dma_left = 16; dma_idx = 0;
`ifdef SH7604_DBUS_ARB_FAIR_EN
    push(32'h06000200, 1'b0, 1'b0);
    push(32'h0A001000, 1'b1, 1'b0);
    push(32'h06000204, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) push(32'h0A001000 + 32'(4 * i), 1'b1, 1'b0);
`else
    for (int i = 0; i < 8; i++) push(32'h0A001000 + 32'(4 * i), 1'b1, 1'b0);
    push(32'h06000200, 1'b0, 1'b0);
    for (int i = 8; i < 16; i++) push(32'h0A001000 + 32'(4 * i), 1'b1, 1'b0);
    push(32'h06000204, 1'b0, 1'b0);
`endif
    drive();
    c = 0;
    seen = 1'b0;
    while ((cpu_left > 0 || dma_left > 0 || exp_q.size() > 0) && c < 200) begin
      step();
      c++;
`ifndef SH7604_DBUS_ARB_FAIR_EN
      if (dma_idx == 7 && !seen) begin
        seen = 1'b1;
        chk("s3_hold_cnt", 32'(hold_cnt), 32'd7);
      end
`endif
    end
    if (c >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL s3_timeout: %0d beats still expected", exp_q.size());
    end
    repeat (2) step();

    // Locked read-modify-write must not be split by the DMAC.
    cpu_base = 32'h06000020; cpu_left = 2; cpu_idx = 0; cpu_inc = 1'b0;
    cpu_lock_cfg = 1'b1; cpu_we_mask = 8'b0000_0010;
    push(32'h06000020, 1'b0, 1'b1);
    push(32'h06000020, 1'b1, 1'b1);
    push(32'h0A000100, 1'b1, 1'b0);
    drive();
    step();
    chk("s4_lock_out", 32'(dbus_bus.lock), 32'd1);
    dma_base = 32'h0A000100; dma_left = 1; dma_idx = 0;
    drive();
    drain("s4", 30);
    cpu_lock_cfg = 1'b0; cpu_inc = 1'b1; cpu_we_mask = 8'h00;
    repeat (2) step();

    // Asynchronous reset while a DMAC beat is stalled by the BSC.
    dbus_bus.busy = 1'b1;
    dma_base = 32'h0A002000; dma_left = 3; dma_idx = 0;
    drive();
    step();
    chk("s6_gnt_dma", 32'(gnt), 32'(G_DMA));
    chk("s6_req", 32'(dbus_bus.req), 32'd1);
    chk("s6_dma_busy", 32'(dma_bus.busy), 32'd1);
    step();
    #2 rst = 1'b1;
    #1;
    chk("s6_async_req", 32'(dbus_bus.req), 32'd0);
    chk("s6_async_gnt", 32'(gnt), 32'(G_NONE));
    chk("s6_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("s6_hold_cnt", 32'(hold_cnt), 32'd0);
    dma_left = 0;
    drive();
    dbus_bus.busy = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("s6_post_req", 32'(dbus_bus.req), 32'd0);
    chk("leftover_beats", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
